// File: rtl/instruction_loader_pkg.sv
// instruction_loader_pkg: pipeline-wide definitions shared by the loader and control unit.
package instruction_loader_pkg;
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_COLLECT = 2'd1;
    localparam state_t ST_WRITE   = 2'd2;
    localparam state_t ST_DONE    = 2'd3;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
endpackage

// File: rtl/instruction_loader_if.sv
// instruction_loader_if: byte stream in, instruction-memory write port and status out.
interface instruction_loader_if #(parameter int NB = 32);
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          instruction_write;
    logic [NB-1:0] address_memory_ins;
    logic [NB-1:0] instruction;
    logic          loading;
    logic          done;
    logic          overflow;
    modport master (output start, rx_data, rx_valid,
                    input instruction_write, address_memory_ins, instruction, loading, done, overflow);
    modport slave  (input start, rx_data, rx_valid,
                    output instruction_write, address_memory_ins, instruction, loading, done, overflow);
endinterface

// File: rtl/instruction_loader_byte_assembler.sv
// byte_assembler: packs four big-endian bytes into a word; word_ready flags the 4th byte.
module byte_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        valid,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_ready
);
    logic [1:0]  cnt;
    logic [23:0] sh;
    assign word       = {sh, data};
    assign word_ready = valid && cnt == 2'd3;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            sh  <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (valid) begin
            cnt <= cnt + 2'd1;
            sh  <= {sh[15:0], data};
        end
    end
endmodule

// File: rtl/instruction_loader.sv
// instruction_loader: loads a UART byte stream into instruction memory, stopping at HALT or when full.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int          NB        = 32,
    parameter int          TAM       = 256,
    parameter logic [NB-1:0] HALT_WORD = NB'(instruction_loader_pkg::HALT_WORD)
) (
    input  logic i_clk,
    input  logic i_reset,
    instruction_loader_if.slave bus
);
    localparam int IW = TAM > 1 ? $clog2(TAM) : 1;
    state_t        state, nxt;
    logic [IW-1:0] idx;
    logic [31:0]   word;
    logic          word_ready, accept, cont;
    // cont: the word now being written is neither HALT nor the last slot
    assign cont   = bus.instruction != HALT_WORD && idx != IW'(TAM - 1);
    assign accept = bus.rx_valid && !bus.start &&
                    (state == ST_COLLECT || (state == ST_WRITE && cont));
    byte_assembler u_asm (
        .clk       (i_clk),
        .reset     (i_reset),
        .clear     (bus.start),
        .valid     (accept),
        .data      (bus.rx_data),
        .word      (word),
        .word_ready(word_ready)
    );
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= ST_IDLE;
        else          state <= nxt;
    end
    always_comb begin
        nxt = bus.start          ? ST_COLLECT :
              state == ST_IDLE    ? ST_IDLE :
              state == ST_COLLECT ? (word_ready ? ST_WRITE : ST_COLLECT) :
              state == ST_WRITE   ? (cont ? ST_COLLECT : ST_DONE) : ST_DONE;
    end
    always_comb begin
        bus.instruction_write = state == ST_WRITE;
        bus.loading           = state == ST_COLLECT || state == ST_WRITE;
        bus.done              = state == ST_DONE;
    end
    // Word and address are latched with the 4th byte so they are stable for the whole WRITE cycle
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            idx                    <= '0;
            bus.instruction        <= '0;
            bus.address_memory_ins <= '0;
            bus.overflow           <= 1'b0;
        end else begin
            if (bus.start) idx <= '0;
            else if (state == ST_WRITE && cont) idx <= idx + 1'b1;
            bus.overflow <= !bus.start && (bus.overflow ||
                            (state == ST_WRITE && bus.instruction != HALT_WORD && !cont));
            if (word_ready) begin
                bus.instruction        <= NB'(word);
                bus.address_memory_ins <= NB'({idx, 2'b00});
            end
        end
    end
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: directed checks of the loader at TAM=256 and TAM=4 driven by one shared stimulus.
module tb_instruction_loader;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    int vecs = 0, errs = 0, n4 = 0, b4, qb;
    logic [31:0] a4 = '0;
    logic [31:0] wa[$], wd[$];

    always #5 clk = ~clk;

    instruction_loader_if #(.NB(32)) bus ();
    instruction_loader_if #(.NB(32)) bus4 ();
    assign bus.start     = start;
    assign bus.rx_data   = rx_data;
    assign bus.rx_valid  = rx_valid;
    assign bus4.start    = start;
    assign bus4.rx_data  = rx_data;
    assign bus4.rx_valid = rx_valid;

    instruction_loader #(.NB(32), .TAM(256)) dut  (.i_clk(clk), .i_reset(rst_n), .bus(bus));
    instruction_loader #(.NB(32), .TAM(4))   dut4 (.i_clk(clk), .i_reset(rst_n), .bus(bus4));

    always @(negedge clk) begin
        if (bus.instruction_write) begin
            wa.push_back(bus.address_memory_ins);
            wd.push_back(bus.instruction);
        end
        if (bus4.instruction_write) begin
            n4 <= n4 + 1;
            a4 <= bus4.address_memory_ins;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send(w[i*8 +: 8]);
    endtask

    task automatic pulse();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        tick(2);
        chk("rst_flags", {bus.loading, bus.done, bus.overflow, bus.instruction_write}, 0);
        chk("rst_instr", bus.instruction, 0);
        rst_n = 1'b1;
        tick(1);
        send_word(32'hDEADBEEF);
        tick(1);
        chk("idle_nowrite", wa.size(), 0);
        chk("idle_loading", bus.loading, 0);
        // 1: single word, one cycle after the 4th strobe
        pulse();
        chk("t1_loading", bus.loading, 1);
        qb = wa.size();
        send(8'h00); send(8'h22); send(8'h08);
        chk("t1_pre", bus.instruction_write, 0);
        send(8'h20);
        chk("t1_wr", bus.instruction_write, 1);
        chk("t1_addr", bus.address_memory_ins, 0);
        chk("t1_instr", bus.instruction, 32'h00220820);
        tick(1);
        chk("t1_wr_off", bus.instruction_write, 0);
        chk("t1_hold", bus.instruction, 32'h00220820);
        chk("t1_count", wa.size() - qb, 1);
        // 2: three words then HALT
        pulse();
        qb = wa.size();
        b4 = n4;
        send_word(32'h11223344);
        send_word(32'h55667788);
        send_word(32'h99AABBCC);
        send_word(32'hFFFFFFFF);
        tick(1);
        chk("t2_done", bus.done, 1);
        chk("t2_ovf", bus.overflow, 0);
        chk("t2_loading", bus.loading, 0);
        chk("t2_count", wa.size() - qb, 4);
        chk("t2_d0", wd[qb], 32'h11223344);
        chk("t2_a1", wa[qb+1], 4);
        chk("t2_a2", wa[qb+2], 8);
        chk("t2_a3", wa[qb+3], 12);
        chk("t2_d3", wd[qb+3], 32'hFFFFFFFF);
        chk("t2_t4_done", bus4.done, 1);
        chk("t2_t4_ovf", bus4.overflow, 0);
        chk("t2_t4_count", n4 - b4, 4);
        send_word(32'h12345678);
        tick(2);
        chk("t2_after_done", wa.size() - qb, 4);
        chk("t2_done_held", bus.done, 1);
        // 3: fill TAM=4 memory without HALT
        pulse();
        chk("t3_done_clr", bus.done, 0);
        b4 = n4;
        qb = wa.size();
        send_word(32'h01010101);
        send_word(32'h02020202);
        send_word(32'h03030303);
        send_word(32'h04040404);
        tick(1);
        chk("t3_t4_ovf", bus4.overflow, 1);
        chk("t3_t4_done", bus4.done, 1);
        chk("t3_t4_loading", bus4.loading, 0);
        chk("t3_t4_count", n4 - b4, 4);
        chk("t3_t4_addr", a4, 12);
        chk("t3_ovf", bus.overflow, 0);
        chk("t3_loading", bus.loading, 1);
        send_word(32'h05050505);
        tick(1);
        chk("t3_a4", wa[qb+4], 16);
        chk("t3_t4_nowr", n4 - b4, 4);
        pulse();
        chk("t3_t4_ovf_clr", bus4.overflow, 0);
        chk("t3_t4_done_clr", bus4.done, 0);
        // 4: restart mid-word; byte coincident with start is dropped
        qb = wa.size();
        send(8'h01); send(8'h02);
        start = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
        tick(1);
        start = 1'b0; rx_valid = 1'b0;
        send(8'hAA); send(8'hBB); send(8'hCC);
        chk("t4_pre", bus.instruction_write, 0);
        send(8'hDD);
        chk("t4_wr", bus.instruction_write, 1);
        chk("t4_addr", bus.address_memory_ins, 0);
        chk("t4_instr", bus.instruction, 32'hAABBCCDD);
        // 5: byte in the WRITE cycle starts the next word
        send_word(32'hA0A1A2A3);
        send_word(32'hB0B1B2B3);
        tick(1);
        chk("t5_count", wa.size() - qb, 3);
        chk("t5_a1", wa[qb+1], 4);
        chk("t5_d1", wd[qb+1], 32'hA0A1A2A3);
        chk("t5_a2", wa[qb+2], 8);
        chk("t5_d2", wd[qb+2], 32'hB0B1B2B3);
        // 6: asynchronous reset mid-word
        qb = wa.size();
        send(8'h01); send(8'h02);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_flags", {bus.loading, bus.done, bus.overflow, bus.instruction_write}, 0);
        chk("t6_instr", bus.instruction, 0);
        chk("t6_addr", bus.address_memory_ins, 0);
        chk("t6_t4_loading", bus4.loading, 0);
        #2 rst_n = 1'b1;
        tick(1);
        send_word(32'h0A0B0C0D);
        tick(2);
        chk("t6_nowrite", wa.size() - qb, 0);
        chk("t6_idle", bus.loading, 0);
        pulse();
        send_word(32'hCAFEF00D);
        chk("t6_wr", bus.instruction_write, 1);
        chk("t6_addr2", bus.address_memory_ins, 0);
        chk("t6_instr2", bus.instruction, 32'hCAFEF00D);
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
